// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down counter with load, start/pause control,
// terminal-count pulse and optional auto-reload.
module bcd_countdown_timer #(
   parameter int DIGITS      = 2,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                start,
   input  logic                stop,
   input  logic                tick,
   output logic [4*DIGITS-1:0] count,
   output logic                running,
   output logic                done,
   output logic                load_err
);

   localparam int W = 4 * DIGITS;

   // bit 0 is set only in RUN so running comes straight off a flop
   localparam logic [2:0] IDLE    = 3'b000;
   localparam logic [2:0] RUN     = 3'b001;
   localparam logic [2:0] PAUSE   = 3'b010;
   localparam logic [2:0] EXPIRED = 3'b100;

   logic [2:0]   state;
   logic [W-1:0] reload;
   logic [W-1:0] dec_val;
   logic         load_ok;
   logic         is_zero;
   logic         dec_zero;
   logic         borrow;

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            load_ok = 1'b0;
         end
      end
   end

   always_comb begin
      borrow  = 1'b1;
      dec_val = count;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (count[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   assign is_zero  = (count == '0);
   assign dec_zero = (dec_val == '0);
   assign running  = state[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         reload   <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         done     <= 1'b0;
         load_err <= 1'b0;
         if (load && load_ok) begin
            count  <= load_val;
            reload <= load_val;
            state  <= IDLE;
         end else begin
            load_err <= load;
            if (stop) begin
               if (state == RUN) begin
                  state <= PAUSE;
               end
            end else if (start && (state == IDLE || state == PAUSE)) begin
               if (!is_zero) begin
                  state <= RUN;
               end
            end else if (tick && state == RUN) begin
               // zero stays visible for one tick before the reload
               if (is_zero) begin
                  if (AUTO_RELOAD && reload != '0) begin
                     count <= reload;
                  end else begin
                     state <= EXPIRED;
                  end
               end else begin
                  count <= dec_val;
                  if (dec_zero) begin
                     done <= 1'b1;
                     if (!AUTO_RELOAD || reload == '0) begin
                        state <= EXPIRED;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: one plain and one auto-reload
// instance share stimulus; each is compared to an integer model.
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] load_val;
   logic       start;
   logic       stop;
   logic       tick;

   logic [7:0] count0, count1;
   logic       running0, running1;
   logic       done0, done1;
   logic       load_err0, load_err1;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_plain (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .tick(tick),
      .count(count0), .running(running0),
      .done(done0), .load_err(load_err0)
   );

   bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_auto (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .tick(tick),
      .count(count1), .running(running1),
      .done(done1), .load_err(load_err1)
   );

   int checks = 0;
   int errors = 0;

   // model state: 0 idle, 1 run, 2 pause, 3 expired; counts as integers
   int m_st[2];
   int m_cnt[2];
   int m_rl[2];
   bit m_dn[2];
   bit m_le[2];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i]  = 0;
         m_cnt[i] = 0;
         m_rl[i]  = 0;
         m_dn[i]  = 1'b0;
         m_le[i]  = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input bit ar);
      bit ok;
      int v;
      ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
      v  = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
      m_dn[i] = 1'b0;
      m_le[i] = 1'b0;
      if (load && ok) begin
         m_cnt[i] = v;
         m_rl[i]  = v;
         m_st[i]  = 0;
      end else begin
         m_le[i] = load;
         if (stop) begin
            if (m_st[i] == 1) m_st[i] = 2;
         end else if (start && (m_st[i] == 0 || m_st[i] == 2)) begin
            if (m_cnt[i] != 0) m_st[i] = 1;
         end else if (tick && m_st[i] == 1) begin
            if (m_cnt[i] == 0) begin
               if (ar && m_rl[i] != 0) m_cnt[i] = m_rl[i];
               else m_st[i] = 3;
            end else begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_dn[i] = 1'b1;
                  if (!ar || m_rl[i] == 0) m_st[i] = 3;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check("plain.count", 32'(count0), 32'(to_bcd(m_cnt[0])));
      check("plain.running", 32'(running0), 32'(m_st[0] == 1));
      check("plain.done", 32'(done0), 32'(m_dn[0]));
      check("plain.load_err", 32'(load_err0), 32'(m_le[0]));
      check("auto.count", 32'(count1), 32'(to_bcd(m_cnt[1])));
      check("auto.running", 32'(running1), 32'(m_st[1] == 1));
      check("auto.done", 32'(done1), 32'(m_dn[1]));
      check("auto.load_err", 32'(load_err1), 32'(m_le[1]));
   endtask

   task automatic cycle(input bit l, input logic [7:0] v,
                        input bit sa, input bit so, input bit t);
      @(negedge clk);
      load     = l;
      load_val = v;
      start    = sa;
      stop     = so;
      tick     = t;
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
      compare_all();
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      load_val = 8'h00;
      start    = 1'b0;
      stop     = 1'b0;
      tick     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cycle(0, 8'h00, 0, 0, 0);

      // asynchronous reset mid-run, checked before any clock edge
      cycle(1, 8'h21, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      @(negedge clk);
      load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 8'h00, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // borrow across digits
      cycle(1, 8'h21, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.first_tick", 32'(count0), 32'h20);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.borrow", 32'(count0), 32'h19);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.third_tick", 32'(count0), 32'h18);

      // expiry and auto-reload
      cycle(1, 8'h02, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.done_pulse", 32'(done0), 32'h1);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.auto_reload", 32'(count1), 32'h02);
      check("plan.expired_hold", 32'(count0), 32'h00);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      check("plan.expired_start", 32'(running0), 32'h0);

      // rejected load
      cycle(1, 8'h15, 0, 0, 0);
      cycle(1, 8'h3a, 0, 0, 0);
      check("plan.load_err", 32'(load_err0), 32'h1);
      check("plan.err_hold", 32'(count0), 32'h15);
      cycle(0, 8'h00, 0, 0, 0);

      // same-cycle priorities
      cycle(1, 8'h11, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 1, 1);
      check("plan.stop_over_tick", 32'(count0), 32'h10);
      cycle(1, 8'h05, 1, 0, 1);
      check("plan.load_over_all", 32'(count0), 32'h05);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [7:0] v;
         if ($urandom_range(0, 3) == 0) begin
            v = 8'($urandom_range(0, 255));
         end else begin
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         cycle($urandom_range(0, 9) == 0, v,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 1) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down counter with load, start/pause control and terminal-count pulse; the decrementing counterpart of the team's BCD up counter.
- Sits between control logic and the BCD display path; counts down on an external enable strobe (tick) so one timebase divider can drive several timers.
- Output digits are always valid BCD (0-9 per nibble).

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- AUTO_RELOAD, 0, 1 = on reaching zero, reload the last accepted load value and keep running.

Ports:
- clk  input  1  system clock, all state updated on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  load request, sampled on rising clk
- load_val  input  4*DIGITS  BCD value to load; nibble 0 = least significant digit
- start  input  1  begin/resume counting
- stop  input  1  pause counting
- tick  input  1  single-cycle decrement enable
- count  output  4*DIGITS  current BCD value
- running  output  1  high in RUN state
- done  output  1  one-cycle pulse when count reaches zero by decrement
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (asynchronous, immediate): count = 0, reload register = 0, state = IDLE, running = 0, done = 0, load_err = 0. Reset mid-count aborts with no done pulse.
- States: IDLE, RUN, PAUSE, EXPIRED. running = (state == RUN). All outputs are registered.
- Same-cycle priority: load > stop > start > tick.
- load, valid value (every nibble <= 9):
  - count and reload register take load_val next edge; state -> IDLE; that cycle's tick is ignored.
  - Accepted in any state.
- load, invalid value (any nibble > 9):
  - count, reload register and state are unchanged; load_err = 1 for exactly one cycle.
  - start, stop and tick in that cycle are still processed normally.
- start:
  - IDLE or PAUSE with count != 0 -> RUN.
  - count == 0 -> ignored, state unchanged.
  - EXPIRED -> ignored; a valid load is required first.
- stop: RUN -> PAUSE; ignored in other states.
- Decrement:
  - Only in RUN with tick = 1 and no load/stop in that cycle.
  - Digit 0 decrements; any digit that is 0 becomes 9 and borrows from the next digit up; others decrement by 1.
  - Single-cycle update, no carry-chain latency.
- Reaching zero:
  - On the edge where a decrement makes count == 0, done = 1 for that one cycle, concurrent with count showing 0.
  - AUTO_RELOAD = 0: state -> EXPIRED; count holds 0.
  - AUTO_RELOAD = 1: on the next tick, count takes the reload register instead of underflowing (zero is displayed for one tick period); state stays RUN.
  - If the reload register is 0, state -> EXPIRED instead.
- count never underflows past 0 with AUTO_RELOAD = 0. tick in IDLE, PAUSE or EXPIRED is ignored.
- done and load_err never assert during or on the first edge after reset.

Test Plan:
- DIGITS=2: rst pulse mid-cycle with no clk edge -> count=0x00, state IDLE immediately; done=0 and load_err=0 on all following edges until stimulus.
- Load 0x21, start, 3 ticks -> count 0x20, 0x19, 0x18 (borrow 0->9 with tens decrement); running=1 throughout.
- Load 0x02, start, 2 ticks -> count 0x01 then 0x00 with done=1 for exactly one cycle; state EXPIRED; further ticks and start leave count 0x00 with no further done.
- Load 0x3A (invalid) while count=0x15 -> load_err=1 for one cycle; count stays 0x15; state unchanged.
- Priorities: RUN at 0x10, assert stop+tick together -> count stays 0x10, state PAUSE. Assert load 0x05 + start + tick together -> count 0x05, state IDLE.
- AUTO_RELOAD=1: load 0x02, start, 4 ticks -> 0x01, 0x00 (done pulse), 0x02, 0x01; running stays 1.
